bilinear_interp: RTL and testbench

//  Pipelined bilinear interpolator directly downstream of the 4-bank image buffer.

---
 rtl/bilinear_interp.sv | 145 ++++++++++++++
 tb/tb_bilinear_interp.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bilinear_interp.sv
// Pipelined bilinear interpolator fed by a 4-bank image buffer.
// Aligns request fractions with buffer data, blends 4 neighbours, counts frame pixels.
module bilinear_interp #(
  parameter int unsigned FRAC_W  = 4,
  parameter int unsigned BUF_LAT = 2,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned OUT_H   = 8,
  parameter logic [7:0]  FILL    = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [FRAC_W-1:0] fx,
  input  logic [FRAC_W-1:0] fy,
  input  logic              oob,
  input  logic [7:0]        lu,
  input  logic [7:0]        ru,
  input  logic [7:0]        ld,
  input  logic [7:0]        rd,
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  output logic              pix_last
);

  localparam int unsigned N    = 1 << FRAC_W;
  localparam int unsigned TW   = 8 + FRAC_W;
  localparam int unsigned VW   = 8 + 2 * FRAC_W;
  localparam int unsigned RW   = 2 + 2 * FRAC_W;
  localparam int unsigned HALF = 1 << (2 * FRAC_W - 1);
  localparam int unsigned NPIX = OUT_W * OUT_H;
  localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(NPIX - 1);

  // Alignment delay line: {valid, oob, fx, fy}
  logic [RW-1:0] dl_q [BUF_LAT];

  logic              tap_valid;
  logic              tap_oob;
  logic [FRAC_W-1:0] tap_fx;
  logic [FRAC_W-1:0] tap_fy;

  assign {tap_valid, tap_oob, tap_fx, tap_fy} = dl_q[BUF_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_LAT; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      dl_q[0] <= {req_valid, oob, fx, fy};
      for (int unsigned i = 1; i < BUF_LAT; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  // Stage 1: horizontal blend
  logic [FRAC_W:0]   wx_r, wx_l;
  logic [TW-1:0]     top_d, bot_d;
  logic              s1_valid_q, s1_oob_q;
  logic [FRAC_W-1:0] s1_fy_q;
  logic [TW-1:0]     s1_top_q, s1_bot_q;

  always_comb begin
    wx_r  = {1'b0, tap_fx};
    wx_l  = (FRAC_W + 1)'(N) - wx_r;
    top_d = TW'(lu) * TW'(wx_l) + TW'(ru) * TW'(wx_r);
    bot_d = TW'(ld) * TW'(wx_l) + TW'(rd) * TW'(wx_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
      s1_fy_q    <= '0;
      s1_top_q   <= '0;
      s1_bot_q   <= '0;
    end else begin
      s1_valid_q <= tap_valid;
      s1_oob_q   <= tap_oob;
      s1_fy_q    <= tap_fy;
      s1_top_q   <= top_d;
      s1_bot_q   <= bot_d;
    end
  end

  // Stage 2: vertical blend
  logic [FRAC_W:0] wy_d, wy_u;
  logic [VW-1:0]   v_d;
  logic            s2_valid_q, s2_oob_q;
  logic [VW-1:0]   s2_v_q;

  always_comb begin
    wy_d = {1'b0, s1_fy_q};
    wy_u = (FRAC_W + 1)'(N) - wy_d;
    v_d  = VW'(s1_top_q) * VW'(wy_u) + VW'(s1_bot_q) * VW'(wy_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_oob_q   <= 1'b0;
      s2_v_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_oob_q   <= s1_oob_q;
      s2_v_q     <= v_d;
    end
  end

  // Stage 3: round half-up, clamp, fill, frame counter
  logic [VW:0]   rnd, shifted;
  logic [7:0]    pix_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    rnd     = (VW + 1)'(s2_v_q) + (VW + 1)'(HALF);
    shifted = rnd >> (2 * FRAC_W);
    if (s2_oob_q) begin
      pix_d = FILL;
    end else if (shifted > (VW + 1)'(255)) begin
      pix_d = 8'hFF;
    end else begin
      pix_d = shifted[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out   <= 8'd0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      cnt_q     <= '0;
    end else if (s2_valid_q) begin
      pix_out   <= pix_d;
      pix_valid <= 1'b1;
      pix_last  <= (cnt_q == LastIdx);
      cnt_q     <= (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
    end else begin
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bilinear_interp.sv
// Directed bench for bilinear_interp: hand-computed pixels, latency, frame-last and reset flush.
module tb_bilinear_interp;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] fx, fy;
  logic       oob;
  logic [7:0] lu, ru, ld, rd;
  logic [7:0] pix_out;
  logic       pix_valid, pix_last;

  bilinear_interp dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .fx        (fx),
    .fy        (fy),
    .oob       (oob),
    .lu        (lu),
    .ru        (ru),
    .ld        (ld),
    .rd        (rd),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_last  (pix_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_seen = 0;
  int model_cnt = 0;
  int exp_q[$];
  int cyc_q[$];

  // Buffer model: pixels offered with a request appear two cycles later
  logic [7:0] h_lu[3], h_ru[3], h_ld[3], h_rd[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] f_x, input logic [3:0] f_y,
                      input logic o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d, input int exp);
    @(posedge clk);
    #1;
    req_valid = v;
    fx = f_x;
    fy = f_y;
    oob = o;
    for (int i = 2; i > 0; i--) begin
      h_lu[i] = h_lu[i-1]; h_ru[i] = h_ru[i-1]; h_ld[i] = h_ld[i-1]; h_rd[i] = h_rd[i-1];
    end
    h_lu[0] = a; h_ru[0] = b; h_ld[0] = c; h_rd[0] = d;
    lu = h_lu[2]; ru = h_ru[2]; ld = h_ld[2]; rd = h_rd[2];
    if (v) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && pix_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        check("pix", int'(pix_out), exp_q.pop_front());
        check("latency", cyc - cyc_q.pop_front(), 5);
        check("last", int'(pix_last), (model_cnt == 63) ? 1 : 0);
        model_cnt = (model_cnt + 1) % 64;
      end
    end else if (!rst && pix_last) begin
      check("last_without_valid", 1, 0);
    end
  end

  initial begin
    int seen_before;
    for (int i = 0; i < 3; i++) begin
      h_lu[i] = 0; h_ru[i] = 0; h_ld[i] = 0; h_rd[i] = 0;
    end
    rst = 1'b1;
    req_valid = 1'b0; fx = 0; fy = 0; oob = 0; lu = 0; ru = 0; ld = 0; rd = 0;
    #23;
    check("rst_pix_out", int'(pix_out), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_pix_last", int'(pix_last), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed blends, with a gap between some to show gaps propagate
    step(1'b1, 4'd0,  4'd0,  1'b0, 8'd37, 8'd200, 8'd200, 8'd200, 37);
    step(1'b1, 4'd8,  4'd8,  1'b0, 8'd0,  8'd255, 8'd0,   8'd255, 128);
    idle(1);
    step(1'b1, 4'd15, 4'd15, 1'b0, 8'd0,  8'd0,   8'd0,   8'd255, 224);
    step(1'b1, 4'd7,  4'd9,  1'b1, 8'd90, 8'd91,  8'd92,  8'd93,  0);
    step(1'b1, 4'd4,  4'd0,  1'b0, 8'd100, 8'd200, 8'd7,  8'd9,   125);
    step(1'b1, 4'd1,  4'd0,  1'b0, 8'd0,  8'd8,   8'd50,  8'd60,  1);
    step(1'b1, 4'd1,  4'd0,  1'b0, 8'd0,  8'd7,   8'd50,  8'd60,  0);
    idle(8);
    check("drain_directed", exp_q.size(), 0);

    // Reset with three requests in flight
    step(1'b1, 4'd0, 4'd0, 1'b0, 8'd11, 8'd0, 8'd0, 8'd0, 11);
    step(1'b1, 4'd0, 4'd0, 1'b0, 8'd12, 8'd0, 8'd0, 8'd0, 12);
    step(1'b1, 4'd0, 4'd0, 1'b0, 8'd13, 8'd0, 8'd0, 8'd0, 13);
    #3 rst = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    model_cnt = 0;
    #1;
    check("flush_pix_out", int'(pix_out), 0);
    check("flush_pix_valid", int'(pix_valid), 0);
    check("flush_pix_last", int'(pix_last), 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    seen_before = valid_seen;
    idle(10);
    check("no_valid_after_rst", valid_seen - seen_before, 0);

    // 65 back-to-back requests: last only on the 64th, 65th wraps to count 0
    seen_before = valid_seen;
    for (int i = 0; i < 65; i++) begin
      step(1'b1, 4'd0, 4'd0, 1'b0, 8'(i), 8'(255 - i), 8'(i ^ 90), 8'd200, i);
    end
    idle(8);
    check("burst_count", valid_seen - seen_before, 65);
    check("hold_pix_out", int'(pix_out), 64);
    idle(3);
    check("hold_pix_out_later", int'(pix_out), 64);
    check("outstanding", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
